// File: rtl/tl_fragment_buffer.sv
// tl_fragment_buffer: splits multi-beat TileLink-style Get/Put requests into
// single-beat downstream transactions and reassembles the responses into an
// upstream response FIFO. Illegal requests are answered locally with errors.
module tl_fragment_buffer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SRC_W    = 2,
  parameter int MAX_SIZE = 6,
  parameter int D_DEPTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [2:0]            a_opcode,
  input  logic [2:0]            a_size,
  input  logic [SRC_W-1:0]      a_source,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [DATA_W/8-1:0]   a_mask,
  input  logic [DATA_W-1:0]     a_data,

  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [2:0]            d_opcode,
  output logic [2:0]            d_size,
  output logic [SRC_W-1:0]      d_source,
  output logic [DATA_W-1:0]     d_data,
  output logic                  d_error,

  output logic                  oa_valid,
  input  logic                  oa_ready,
  output logic [2:0]            oa_opcode,
  output logic [2:0]            oa_size,
  output logic [SRC_W-1:0]      oa_source,
  output logic [ADDR_W-1:0]     oa_address,
  output logic [DATA_W/8-1:0]   oa_mask,
  output logic [DATA_W-1:0]     oa_data,

  input  logic                  od_valid,
  output logic                  od_ready,
  input  logic [2:0]            od_opcode,
  input  logic [2:0]            od_size,
  input  logic [SRC_W-1:0]      od_source,
  input  logic [DATA_W-1:0]     od_data,
  input  logic                  od_error
);

  localparam int MASK_W = DATA_W / 8;
  localparam int LGB    = $clog2(MASK_W);
  // Wide enough to count up to the beat total of a size-7 transfer.
  localparam int CNT_W  = 8 - LGB;
  localparam int PTR_W  = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
  localparam int FCNT_W = $clog2(D_DEPTH + 1);

  localparam logic [2:0] LGB_SZ = 3'(LGB);
  localparam logic [2:0] MAX_SZ = 3'(MAX_SIZE);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef enum logic [2:0] {IDLE, GET, PUT, WAIT, ERR} state_t;

  // Index of the last beat (beat count minus one) for a given transfer size.
  function automatic logic [CNT_W-1:0] last_beat_of(input logic [2:0] sz);
    logic [CNT_W-1:0] one;
    one = CNT_W'(1);
    return (sz > LGB_SZ) ? (one << (sz - LGB_SZ)) - one : '0;
  endfunction

  function automatic logic [2:0] beat_size_of(input logic [2:0] sz);
    return (sz > LGB_SZ) ? LGB_SZ : sz;
  endfunction

  function automatic logic is_put_op(input logic [2:0] op);
    return (op == OP_PUT_FULL) || (op == OP_PUT_PARTIAL);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(D_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_t state, state_next;

  logic [2:0]        hdr_opcode;
  logic [2:0]        hdr_size;
  logic [SRC_W-1:0]  hdr_source;
  logic [ADDR_W-1:0] hdr_address;
  logic [MASK_W-1:0] hdr_mask;
  logic [CNT_W-1:0]  last_beat;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  resp_cnt;
  logic              sticky_err;

  logic              a_ready_c, oa_valid_c, od_ready_c;
  logic [2:0]        oa_opcode_c, oa_size_c;
  logic [SRC_W-1:0]  oa_source_c;
  logic [ADDR_W-1:0] oa_address_c;
  logic [MASK_W-1:0] oa_mask_c;
  logic [DATA_W-1:0] oa_data_c;

  logic              enq_valid;
  logic [2:0]        enq_opcode;
  logic [DATA_W-1:0] enq_data;
  logic              enq_error;
  logic              resp_final;
  logic              sticky_set;

  logic [2:0]        fifo_opcode [D_DEPTH];
  logic [2:0]        fifo_size   [D_DEPTH];
  logic [SRC_W-1:0]  fifo_source [D_DEPTH];
  logic [DATA_W-1:0] fifo_data   [D_DEPTH];
  logic              fifo_error  [D_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty, deq;

  logic              a_legal, a_is_put;
  logic [CNT_W-1:0]  a_last;
  logic              hdr_is_put, hdr_is_get;
  logic              a_fire, oa_fire, od_fire;
  logic              beat_is_last, err_drain;
  logic [ADDR_W-1:0] beat_offset;
  logic              unused_od_fields;

  assign a_is_put     = is_put_op(a_opcode);
  assign a_legal      = (a_is_put || (a_opcode == OP_GET)) && (a_size <= MAX_SZ);
  assign a_last       = last_beat_of(a_size);
  assign hdr_is_put   = is_put_op(hdr_opcode);
  assign hdr_is_get   = (hdr_opcode == OP_GET);
  assign a_fire       = a_valid && a_ready;
  assign oa_fire      = oa_valid && oa_ready;
  assign od_fire      = od_valid && od_ready;
  assign beat_is_last = (beat_cnt == last_beat);
  // An illegal Put still has to swallow its remaining data beats.
  assign err_drain    = hdr_is_put && (beat_cnt <= last_beat);
  assign beat_offset  = ADDR_W'(beat_cnt) << LGB;

  // Downstream response header fields carry nothing we need.
  assign unused_od_fields = ^{od_opcode, od_size, od_source};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: one upstream transaction at a time.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (a_fire) begin
          if (!a_legal)             state_next = ERR;
          else if (!a_is_put)       state_next = GET;
          else if (a_last != '0)    state_next = PUT;
          else                      state_next = WAIT;
        end
      end
      GET: begin
        if (resp_final)                  state_next = IDLE;
        else if (oa_fire && beat_is_last) state_next = WAIT;
      end
      PUT: begin
        if (resp_final)                  state_next = IDLE;
        else if (oa_fire && beat_is_last) state_next = WAIT;
      end
      WAIT: if (resp_final) state_next = IDLE;
      ERR:  if (resp_final) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and downstream request outputs; Puts stream through, Gets come from the header.
  always_comb begin
    a_ready_c    = 1'b0;
    oa_valid_c   = 1'b0;
    od_ready_c   = 1'b0;
    oa_opcode_c  = hdr_opcode;
    oa_size_c    = beat_size_of(hdr_size);
    oa_source_c  = hdr_source;
    oa_address_c = hdr_address + beat_offset;
    oa_mask_c    = (last_beat != '0) ? '1 : hdr_mask;
    oa_data_c    = a_data;
    case (state)
      IDLE: begin
        oa_opcode_c  = a_opcode;
        oa_size_c    = beat_size_of(a_size);
        oa_source_c  = a_source;
        oa_address_c = a_address;
        oa_mask_c    = (a_last != '0) ? '1 : a_mask;
        if (a_legal && a_is_put) begin
          oa_valid_c = a_valid;
          a_ready_c  = oa_ready;
        end else begin
          a_ready_c  = 1'b1;
        end
      end
      GET: begin
        oa_valid_c  = 1'b1;
        oa_opcode_c = OP_GET;
        oa_data_c   = '0;
        od_ready_c  = !fifo_full;
      end
      PUT: begin
        oa_valid_c = a_valid;
        a_ready_c  = oa_ready;
        od_ready_c = !fifo_full;
      end
      WAIT: od_ready_c = !fifo_full;
      ERR:  a_ready_c  = err_drain;
      default: ;
    endcase
  end

  assign a_ready    = a_ready_c && reset_n;
  assign oa_valid   = oa_valid_c && reset_n;
  assign od_ready   = od_ready_c && reset_n;
  assign oa_opcode  = oa_opcode_c;
  assign oa_size    = oa_size_c;
  assign oa_source  = oa_source_c;
  assign oa_address = oa_address_c;
  assign oa_mask    = oa_mask_c;
  assign oa_data    = oa_data_c;

  // Response path: pass Get data, fold Put acks into one, or synthesize error beats.
  always_comb begin
    enq_valid  = 1'b0;
    enq_opcode = OP_ACK;
    enq_data   = '0;
    enq_error  = 1'b0;
    resp_final = 1'b0;
    sticky_set = 1'b0;
    if (od_fire) begin
      if (hdr_is_put) begin
        if (resp_cnt == last_beat) begin
          enq_valid  = 1'b1;
          enq_error  = sticky_err || od_error;
          resp_final = 1'b1;
        end else begin
          sticky_set = od_error;
        end
      end else begin
        enq_valid  = 1'b1;
        enq_opcode = OP_ACK_DATA;
        enq_data   = od_data;
        enq_error  = od_error;
        resp_final = (resp_cnt == last_beat);
      end
    end else if ((state == ERR) && !err_drain && !fifo_full) begin
      enq_valid  = 1'b1;
      enq_opcode = hdr_is_get ? OP_ACK_DATA : OP_ACK;
      enq_error  = 1'b1;
      resp_final = !hdr_is_get || (resp_cnt == last_beat);
    end
  end

  // Header capture and beat/response bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hdr_opcode  <= '0;
      hdr_size    <= '0;
      hdr_source  <= '0;
      hdr_address <= '0;
      hdr_mask    <= '0;
      last_beat   <= '0;
      beat_cnt    <= '0;
      resp_cnt    <= '0;
      sticky_err  <= 1'b0;
    end else if ((state == IDLE) && a_fire) begin
      hdr_opcode  <= a_opcode;
      hdr_size    <= a_size;
      hdr_source  <= a_source;
      hdr_address <= a_address;
      hdr_mask    <= a_mask;
      last_beat   <= a_last;
      beat_cnt    <= a_is_put ? CNT_W'(1) : '0;
      resp_cnt    <= '0;
      sticky_err  <= 1'b0;
    end else begin
      if (oa_fire || ((state == ERR) && a_fire))
        beat_cnt <= beat_cnt + CNT_W'(1);
      if (resp_final) begin
        resp_cnt   <= '0;
        sticky_err <= 1'b0;
      end else begin
        if (od_fire || enq_valid)
          resp_cnt <= resp_cnt + CNT_W'(1);
        if (sticky_set)
          sticky_err <= 1'b1;
      end
    end
  end

  assign fifo_full  = (fifo_count == FCNT_W'(D_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign deq        = d_valid && d_ready;

  // Response FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clock) begin
    if (enq_valid) begin
      fifo_opcode[wr_ptr] <= enq_opcode;
      fifo_size[wr_ptr]   <= hdr_size;
      fifo_source[wr_ptr] <= hdr_source;
      fifo_data[wr_ptr]   <= enq_data;
      fifo_error[wr_ptr]  <= enq_error;
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (enq_valid) wr_ptr <= next_ptr(wr_ptr);
      if (deq)       rd_ptr <= next_ptr(rd_ptr);
      if (enq_valid && !deq)      fifo_count <= fifo_count + FCNT_W'(1);
      else if (!enq_valid && deq) fifo_count <= fifo_count - FCNT_W'(1);
    end
  end

  assign d_valid  = !fifo_empty && reset_n;
  assign d_opcode = fifo_opcode[rd_ptr];
  assign d_size   = fifo_size[rd_ptr];
  assign d_source = fifo_source[rd_ptr];
  assign d_data   = fifo_data[rd_ptr];
  assign d_error  = fifo_error[rd_ptr];

endmodule

// File: tb/tb_tl_fragment_buffer.sv
// tb_tl_fragment_buffer: directed self-checking bench for tl_fragment_buffer.
module tb_tl_fragment_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SRC_W  = 2;
  localparam int MASK_W = DATA_W / 8;

  logic              clock;
  logic              reset_n;
  logic              a_valid, a_ready;
  logic [2:0]        a_opcode, a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [MASK_W-1:0] a_mask;
  logic [DATA_W-1:0] a_data;
  logic              d_valid, d_ready;
  logic [2:0]        d_opcode, d_size;
  logic [SRC_W-1:0]  d_source;
  logic [DATA_W-1:0] d_data;
  logic              d_error;
  logic              oa_valid, oa_ready;
  logic [2:0]        oa_opcode, oa_size;
  logic [SRC_W-1:0]  oa_source;
  logic [ADDR_W-1:0] oa_address;
  logic [MASK_W-1:0] oa_mask;
  logic [DATA_W-1:0] oa_data;
  logic              od_valid, od_ready;
  logic [2:0]        od_opcode, od_size;
  logic [SRC_W-1:0]  od_source;
  logic [DATA_W-1:0] od_data;
  logic              od_error;

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  tl_fragment_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W), .MAX_SIZE(6), .D_DEPTH(2)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data), .d_error(d_error),
    .oa_valid(oa_valid), .oa_ready(oa_ready), .oa_opcode(oa_opcode), .oa_size(oa_size),
    .oa_source(oa_source), .oa_address(oa_address), .oa_mask(oa_mask), .oa_data(oa_data),
    .od_valid(od_valid), .od_ready(od_ready), .od_opcode(od_opcode), .od_size(od_size),
    .od_source(od_source), .od_data(od_data), .od_error(od_error)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] op, input logic [2:0] sz,
                                input logic [SRC_W-1:0] src, input logic [ADDR_W-1:0] addr,
                                input logic [MASK_W-1:0] mask, input logic [DATA_W-1:0] data);
    a_valid   = v;
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    apply_stimulus(1'b1, 3'd4, 3'd2, 2'd0, 32'h0, 4'hF, 32'h0);
    oa_ready = 1'b1;
    d_ready  = 1'b1;
    od_valid = 1'b1;
    od_opcode = 3'd1; od_size = 3'd2; od_source = '0; od_data = '0; od_error = 1'b0;
    #1;
    $display("[TB] reset state");
    check_output("rst_a_ready", a_ready, 1'b0);
    check_output("rst_oa_valid", oa_valid, 1'b0);
    check_output("rst_d_valid", d_valid, 1'b0);
    check_output("rst_od_ready", od_ready, 1'b0);
    step(); step();
    a_valid = 1'b0; od_valid = 1'b0;
    reset_n = 1'b1;

    // Get size 4 at 0x100 from source 1: four size-2 Gets, four data beats back.
    $display("[TB] get size 4");
    step();
    apply_stimulus(1'b1, 3'd4, 3'd4, 2'd1, 32'h100, 4'hF, 32'h0);
    @(negedge clock);
    check_output("get4_a_ready", a_ready, 1'b1);
    check_output("get4_idle_oa_valid", oa_valid, 1'b0);
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_output("get4_oa_valid", oa_valid, 1'b1);
      check_output("get4_oa_address", oa_address, 32'h100 + 32'(4 * k));
      check_output("get4_oa_size", oa_size, 3'd2);
      check_output("get4_oa_opcode", oa_opcode, 3'd4);
      check_output("get4_oa_source", oa_source, 2'd1);
      step();
    end
    @(negedge clock);
    check_output("get4_wait_oa_valid", oa_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      od_valid = 1'b1; od_data = 32'hA0 + 32'(k); od_error = 1'b0;
      @(negedge clock);
      check_output("get4_od_ready", od_ready, 1'b1);
      if (k > 0) begin
        check_output("get4_d_data", d_data, 32'hA0 + 32'(k - 1));
        check_output("get4_d_size", d_size, 3'd4);
        check_output("get4_d_source", d_source, 2'd1);
        check_output("get4_d_opcode", d_opcode, 3'd1);
      end
    end
    step();
    od_valid = 1'b0;
    @(negedge clock);
    check_output("get4_last_d_valid", d_valid, 1'b1);
    check_output("get4_last_d_data", d_data, 32'hA3);
    check_output("get4_idle_od_ready", od_ready, 1'b0);
    step();
    @(negedge clock);
    check_output("get4_drained", d_valid, 1'b0);

    // PutFull size 3 at 0x40: two beats, second ack reports an error.
    $display("[TB] put size 3");
    step();
    d_ready = 1'b0;
    apply_stimulus(1'b1, 3'd0, 3'd3, 2'd2, 32'h40, 4'hF, 32'h11111111);
    @(negedge clock);
    check_output("put_b0_oa_valid", oa_valid, 1'b1);
    check_output("put_b0_a_ready", a_ready, 1'b1);
    check_output("put_b0_oa_address", oa_address, 32'h40);
    check_output("put_b0_oa_size", oa_size, 3'd2);
    check_output("put_b0_oa_data", oa_data, 32'h11111111);
    step();
    a_data = 32'h22222222;
    @(negedge clock);
    check_output("put_b1_oa_valid", oa_valid, 1'b1);
    check_output("put_b1_oa_address", oa_address, 32'h44);
    check_output("put_b1_oa_data", oa_data, 32'h22222222);
    check_output("put_b1_oa_mask", oa_mask, 4'hF);
    step();
    a_valid = 1'b0;
    od_valid = 1'b1; od_opcode = 3'd0; od_error = 1'b0; od_data = '0;
    @(negedge clock);
    check_output("put_wait_oa_valid", oa_valid, 1'b0);
    step();
    od_error = 1'b1;
    @(negedge clock);
    check_output("put_ack1_absorbed", d_valid, 1'b0);
    step();
    od_valid = 1'b0; od_error = 1'b0;
    @(negedge clock);
    check_output("put_ack_d_valid", d_valid, 1'b1);
    check_output("put_ack_d_opcode", d_opcode, 3'd0);
    check_output("put_ack_d_size", d_size, 3'd3);
    check_output("put_ack_d_source", d_source, 2'd2);
    check_output("put_ack_d_error", d_error, 1'b1);
    step();
    d_ready = 1'b1;
    step();
    @(negedge clock);
    check_output("put_single_ack", d_valid, 1'b0);

    // Get size 0 at 0x3, mask 0x8: one narrow Get, held while stalled.
    $display("[TB] get size 0");
    step();
    apply_stimulus(1'b1, 3'd4, 3'd0, 2'd3, 32'h3, 4'h8, 32'h0);
    oa_ready = 1'b0;
    @(negedge clock);
    check_output("get0_a_ready", a_ready, 1'b1);
    step();
    a_valid = 1'b0;
    @(negedge clock);
    check_output("get0_oa_valid", oa_valid, 1'b1);
    check_output("get0_oa_size", oa_size, 3'd0);
    check_output("get0_oa_address", oa_address, 32'h3);
    check_output("get0_oa_mask", oa_mask, 4'h8);
    step();
    @(negedge clock);
    check_output("get0_hold_oa_valid", oa_valid, 1'b1);
    check_output("get0_hold_oa_address", oa_address, 32'h3);
    step();
    oa_ready = 1'b1;
    step();
    od_valid = 1'b1; od_opcode = 3'd1; od_data = 32'h55; od_error = 1'b0;
    @(negedge clock);
    check_output("get0_single_oa", oa_valid, 1'b0);
    step();
    od_valid = 1'b0;
    @(negedge clock);
    check_output("get0_d_valid", d_valid, 1'b1);
    check_output("get0_d_data", d_data, 32'h55);
    check_output("get0_d_size", d_size, 3'd0);
    check_output("get0_d_source", d_source, 2'd3);
    step();
    @(negedge clock);
    check_output("get0_drained", d_valid, 1'b0);

    // Get size 4 with d_ready low: FIFO fills at two and backpressures.
    $display("[TB] backpressure");
    step();
    d_ready = 1'b0;
    apply_stimulus(1'b1, 3'd4, 3'd4, 2'd0, 32'h200, 4'hF, 32'h0);
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_output("bp_oa_address", oa_address, 32'h200 + 32'(4 * k));
      step();
    end
    od_valid = 1'b1; od_data = 32'hB0;
    @(negedge clock);
    check_output("bp_od_ready0", od_ready, 1'b1);
    step();
    od_data = 32'hB1;
    @(negedge clock);
    check_output("bp_od_ready1", od_ready, 1'b1);
    step();
    od_data = 32'hB2;
    @(negedge clock);
    check_output("bp_full_od_ready", od_ready, 1'b0);
    check_output("bp_full_head", d_data, 32'hB0);
    step();
    d_ready = 1'b1;
    @(negedge clock);
    check_output("bp_release_od_ready", od_ready, 1'b0);
    check_output("bp_release_head", d_data, 32'hB0);
    step();
    @(negedge clock);
    check_output("bp_reopen_od_ready", od_ready, 1'b1);
    check_output("bp_head_b1", d_data, 32'hB1);
    step();
    od_data = 32'hB3;
    @(negedge clock);
    check_output("bp_head_b2", d_data, 32'hB2);
    step();
    od_valid = 1'b0;
    @(negedge clock);
    check_output("bp_last_d_valid", d_valid, 1'b1);
    check_output("bp_head_b3", d_data, 32'hB3);
    step();
    @(negedge clock);
    check_output("bp_drained", d_valid, 1'b0);

    // Illegal Get size 7: nothing downstream, 32 error beats upstream.
    $display("[TB] illegal get size 7");
    step();
    apply_stimulus(1'b1, 3'd4, 3'd7, 2'd2, 32'h0, 4'hF, 32'h0);
    @(negedge clock);
    check_output("ill_a_ready", a_ready, 1'b1);
    check_output("ill_idle_oa_valid", oa_valid, 1'b0);
    step();
    a_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      check_output("ill_oa_valid", oa_valid, 1'b0);
      if (d_valid) begin
        check_output("ill_d_error", d_error, 1'b1);
        check_output("ill_d_data", d_data, 32'h0);
        check_output("ill_d_opcode", d_opcode, 3'd1);
        check_output("ill_d_size", d_size, 3'd7);
        check_output("ill_d_source", d_source, 2'd2);
        beats++;
      end
    end
    check_output("ill_beat_count", 64'(beats), 64'd32);

    // Reset after the first Put beat with a response still buffered.
    $display("[TB] mid-transaction reset");
    step();
    d_ready = 1'b0;
    apply_stimulus(1'b1, 3'd4, 3'd2, 2'd1, 32'h300, 4'hF, 32'h0);
    step();
    a_valid = 1'b0;
    step();
    od_valid = 1'b1; od_data = 32'h77;
    step();
    od_valid = 1'b0;
    @(negedge clock);
    check_output("rst2_buffered_d_valid", d_valid, 1'b1);
    check_output("rst2_buffered_d_data", d_data, 32'h77);
    step();
    apply_stimulus(1'b1, 3'd0, 3'd3, 2'd2, 32'h80, 4'hF, 32'hC0);
    step();
    a_data = 32'hC1;
    @(negedge clock);
    check_output("rst2_put_oa_valid", oa_valid, 1'b1);
    check_output("rst2_put_oa_address", oa_address, 32'h84);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rst2_a_ready", a_ready, 1'b0);
    check_output("rst2_oa_valid", oa_valid, 1'b0);
    check_output("rst2_d_valid", d_valid, 1'b0);
    check_output("rst2_od_ready", od_ready, 1'b0);
    step(); step();
    a_valid = 1'b0;
    reset_n = 1'b1;
    step();
    d_ready = 1'b1;
    apply_stimulus(1'b1, 3'd4, 3'd2, 2'd0, 32'h0, 4'hF, 32'h0);
    @(negedge clock);
    check_output("post_a_ready", a_ready, 1'b1);
    check_output("post_fifo_flushed", d_valid, 1'b0);
    step();
    a_valid = 1'b0;
    @(negedge clock);
    check_output("post_oa_valid", oa_valid, 1'b1);
    check_output("post_oa_address", oa_address, 32'h0);
    step();
    od_valid = 1'b1; od_data = 32'h99; od_error = 1'b0;
    @(negedge clock);
    check_output("post_oa_done", oa_valid, 1'b0);
    step();
    od_valid = 1'b0;
    @(negedge clock);
    check_output("post_d_valid", d_valid, 1'b1);
    check_output("post_d_data", d_data, 32'h99);
    check_output("post_d_error", d_error, 1'b0);
    check_output("post_d_size", d_size, 3'd2);
    step();
    @(negedge clock);
    check_output("post_drained", d_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_fragment_buffer.md
TL_FRAGMENT_BUFFER -- requirements
Module: tl_fragment_buffer

Interface
REQ-001 Parameter DATA_W, 32, beat width in bits (power of 2, >=32); LGB = log2(DATA_W/8).
REQ-002 Parameter ADDR_W, 32, address width.
REQ-003 Parameter SRC_W, 2, source-ID width.
REQ-004 Parameter MAX_SIZE, 6, largest legal log2 transfer size in bytes (LGB..7).
REQ-005 Parameter D_DEPTH, 2, upstream response FIFO entries (>=1).
REQ-006 clock  in  1  single rising-edge clock for all state.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 a_valid in 1, a_ready out 1: upstream request handshake.
REQ-009 a_opcode in 3, a_size in 3, a_source in SRC_W, a_address in ADDR_W, a_mask in DATA_W/8, a_data in DATA_W: upstream request payload.
REQ-010 d_valid out 1, d_ready in 1: upstream response handshake.
REQ-011 d_opcode out 3, d_size out 3, d_source out SRC_W, d_data out DATA_W, d_error out 1: upstream response payload.
REQ-012 oa_valid/oa_ready and oa_opcode/size/source/address/mask/data: downstream request, same widths as a_*, directions reversed.
REQ-013 od_valid/od_ready and od_opcode/size/source/data/error: downstream response, same widths as d_*, directions reversed.

Function
REQ-014 Opcodes: A: PutFull=0, PutPartial=1, Get=4. D: AccessAck=0, AccessAckData=1. Transfer occurs on valid&ready.
REQ-015 Beat count N = 2^(a_size-LGB) if a_size>LGB, else 1. Beat counter is sized for a_size=7.
REQ-016 Downstream beat k: size = min(a_size,LGB), address = a_address + k*(DATA_W/8), source = captured a_source. Mask = all ones if N>1, else a_mask unchanged.
REQ-017 Legal request: opcode in {0,1,4} and a_size<=MAX_SIZE. Any other request is illegal (REQ-023).
REQ-018 States: IDLE, GET, PUT, WAIT, ERR. Exactly one upstream transaction is in progress at a time.
REQ-019 IDLE, legal Get: a_ready=1. Capture header; go to GET.
 - GET: issue N single-beat Gets, one per oa handshake, back-to-back allowed.
 - After the Nth handshake, go to WAIT.
REQ-020 IDLE/PUT, legal Put: pass-through, oa_valid=a_valid, a_ready=oa_ready, oa_data=a_data.
 - First beat captures the header in IDLE; N>1 goes to PUT, N=1 goes to WAIT.
 - The Nth beat handshake in PUT goes to WAIT.
REQ-021 od_ready = !fifo_full in GET/PUT/WAIT; 0 in IDLE/ERR. There is no combinational path from d_ready to od_ready.
REQ-022 Response handling:
 - Get: every od beat is enqueued with d_size=captured a_size and d_source=captured source; data and error pass through.
 - Put: acks 1..N-1 are absorbed and their od_error is ORed into a sticky bit. Ack N is enqueued with d_error = sticky|od_error and d_size = captured a_size.
 - Enqueuing the final response returns the block to IDLE and clears the sticky bit.
REQ-023 Illegal requests are never forwarded downstream (oa_valid=0).
 - IDLE accepts with a_ready=1; Puts consume all N beats; then go to ERR.
 - ERR enqueues N AccessAckData beats for Get, or 1 AccessAck otherwise, each with d_error=1, d_data=0 and the captured size/source; then IDLE.
REQ-024 FIFO: D_DEPTH entries, in order, d_* driven from head, d_valid = !empty. Enqueue and dequeue in the same cycle are allowed when not full. Full blocks enqueue only.
REQ-025 oa_valid never depends on oa_ready. d_valid never depends on d_ready. Payload is held stable while valid&!ready.
REQ-026 A new transaction may be accepted in IDLE while earlier responses remain in the FIFO; ordering is preserved.

Reset
REQ-027 While reset_n=0: state=IDLE, FIFO empty, counters=0, sticky=0. d_valid, oa_valid, a_ready and od_ready are forced 0, asynchronously.
REQ-028 Reset mid-transaction discards all in-flight state and buffered responses. The first legal request after reset_n rises is accepted normally.

Verification
REQ-029 Get size=4, addr 0x100, src 1 (DATA_W=32) -> oa Gets size 2 at 0x100/0x104/0x108/0x10C; 4 AccessAckData beats, size 4, src 1, in order.
REQ-030 PutFull size=3, addr 0x40, 2 beats; second od ack error=1 -> exactly one upstream AccessAck, size 3, d_error=1.
REQ-031 Get size=7 with MAX_SIZE=6 -> oa_valid stays 0; 32 AccessAckData beats, d_error=1, d_data=0.
REQ-032 Get size=0, addr 0x3, mask 0x8 -> single oa Get, size 0, addr 0x3, mask 0x8 unchanged.
REQ-033 Get size=4, D_DEPTH=2, d_ready=0 -> od_ready=0 after 2 enqueues; releasing d_ready delivers all 4 beats, no loss or reorder.
REQ-034 reset_n=0 after first Put beat -> a_ready/oa_valid/d_valid=0 in the same cycle; after release, a Get at 0x0 completes normally.
